// File: rtl/nonogram_line_scheduler_pkg.sv
// Shared constants, scheduler state encoding and slot mapping for the nonogram line scheduler.
package nonogram_pkg;

  localparam int unsigned MAX_SIZE  = 11;
  localparam int unsigned OPT_W     = 16;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned NUM_SLOTS = 2 * MAX_SIZE;
  localparam int unsigned IDX_W     = $clog2(NUM_SLOTS);

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StIssue,
    StWait,
    StPush,
    StNext,
    StSolved,
    StStuck,
    StContra
  } sched_state_e;

  // Rows occupy slots 0..MAX_SIZE-1, columns MAX_SIZE..2*MAX_SIZE-1.
  function automatic logic [IDX_W-1:0] slot_of(input logic is_col, input logic [IDX_W-1:0] idx);
    return is_col ? (idx + IDX_W'(MAX_SIZE)) : idx;
  endfunction

endpackage

// File: rtl/nonogram_line_scheduler_if.sv
// Option FIFO and line-solver handshake bundle; master is the scheduler side.
interface nonogram_line_scheduler_if;
  import nonogram_pkg::*;

  logic             fifo_empty;
  logic [OPT_W-1:0] fifo_dout;
  logic             fifo_rd;
  logic             fifo_wr;
  logic [OPT_W-1:0] fifo_din;
  logic             sol_valid;
  logic             sol_is_header;
  logic [OPT_W-1:0] sol_data;
  logic             sol_ready;
  logic             res_valid;
  logic             res_keep;

  modport master (
    input  fifo_empty, fifo_dout, sol_ready, res_valid, res_keep,
    output fifo_rd, fifo_wr, fifo_din, sol_valid, sol_is_header, sol_data
  );

  modport slave (
    output fifo_empty, fifo_dout, sol_ready, res_valid, res_keep,
    input  fifo_rd, fifo_wr, fifo_din, sol_valid, sol_is_header, sol_data
  );

endinterface

// File: rtl/nonogram_line_iter.sv
// Active-slot iterator: next slot after line_i, pass wrap flag and first slot of a new pass.
// Build option SKIP_SETTLED_EN: slots whose count is 1 are skipped once skip_i is set.
module nonogram_line_iter
  import nonogram_pkg::*;
(
  input  logic [IDX_W-1:0]     line_i,
  input  logic [3:0]           num_rows_i,
  input  logic [3:0]           num_cols_i,
`ifdef SKIP_SETTLED_EN
  input  logic [NUM_SLOTS-1:0] settled_i,
  input  logic                 skip_i,
`endif
  output logic [NUM_SLOTS-1:0] active_o,
  output logic [IDX_W-1:0]     next_o,
  output logic                 wrap_o,
  output logic [IDX_W-1:0]     first_o
);

  logic [NUM_SLOTS-1:0] elig_next;
  logic [NUM_SLOTS-1:0] elig_first;
  logic                 first_found;

  // Mark row and column slots in use for this grid size.
  always_comb begin : p_active
    active_o = '0;
    for (int i = 0; i < int'(MAX_SIZE); i++) begin
      active_o[slot_of(1'b0, IDX_W'(i))] = (i < int'(num_rows_i));
      active_o[slot_of(1'b1, IDX_W'(i))] = (i < int'(num_cols_i));
    end
  end

  // Slots eligible as the next visit; a new pass always starts at pass >= 1.
  always_comb begin : p_elig
`ifdef SKIP_SETTLED_EN
    elig_next  = active_o & ~(settled_i & {NUM_SLOTS{skip_i}});
    elig_first = active_o & ~settled_i;
`else
    elig_next  = active_o;
    elig_first = active_o;
`endif
  end

  // Priority search for the next eligible slot above line_i and the lowest eligible slot.
  always_comb begin : p_search
    next_o      = '0;
    wrap_o      = 1'b1;
    first_o     = '0;
    first_found = 1'b0;
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      if (wrap_o && (s > int'(line_i)) && elig_next[s]) begin
        wrap_o = 1'b0;
        next_o = IDX_W'(s);
      end
      if (!first_found && elig_first[s]) begin
        first_found = 1'b1;
        first_o     = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/nonogram_line_scheduler.sv
// Nonogram line scheduler: walks active row/column slots, streams each line's options from the
// shared FIFO through the solver, re-queues kept options and tracks per-slot option counts until
// the puzzle is solved, stuck or contradictory.
// Build option SKIP_SETTLED_EN: from pass 1 on, slots with a single option are not revisited.
module nonogram_line_scheduler
  import nonogram_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [3:0]                      num_rows_i,
  input  logic [3:0]                      num_cols_i,
  input  logic                            cnt_wr_en_i,
  input  logic [IDX_W-1:0]                cnt_wr_idx_i,
  input  logic [CNT_W-1:0]                cnt_wr_val_i,
  nonogram_line_scheduler_if.master       bus_io,
  output logic [NUM_SLOTS-1:0][CNT_W-1:0] old_options_amnt_o,
  output logic [7:0]                      pass_cnt_o,
  output logic                            busy_o,
  output logic                            solved_o,
  output logic                            stuck_o,
  output logic                            contradiction_o
);

  sched_state_e                  state_q, state_d;
  logic [IDX_W-1:0]              line_q, line_d;
  logic [CNT_W-1:0]              kept_q, kept_d;
  logic [CNT_W-1:0]              opt_k_q, opt_k_d;
  logic                          changed_q, changed_d;
  logic [OPT_W-1:0]              hold_q, hold_d;
  logic [NUM_SLOTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]                    pass_q, pass_d;
  logic                          solved_q, solved_d;
  logic                          stuck_q, stuck_d;
  logic                          contra_q, contra_d;

  logic [NUM_SLOTS-1:0] active;
  logic [NUM_SLOTS-1:0] settled;
  logic                 all_one;
  logic [IDX_W-1:0]     next_line;
  logic [IDX_W-1:0]     first_line;
  logic                 wrap;
  logic [CNT_W-1:0]     cur_cnt;
  logic [CNT_W-1:0]     kept_nxt;
  logic [CNT_W-1:0]     opt_nxt;
  logic                 line_step;
  logic                 eol;

  nonogram_line_iter u_iter (
    .line_i     (line_q),
    .num_rows_i (num_rows_i),
    .num_cols_i (num_cols_i),
`ifdef SKIP_SETTLED_EN
    .settled_i  (settled),
    .skip_i     (pass_q != 8'd0),
`endif
    .active_o   (active),
    .next_o     (next_line),
    .wrap_o     (wrap),
    .first_o    (first_line)
  );

  // Settled slots and the solved test over the active slots.
  always_comb begin : p_settled
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      settled[s] = (cnt_q[s] == CNT_W'(1));
    end
    all_one = &(settled | ~active);
  end

  // Per-option bookkeeping: a dropped verdict or a push both finish one option of the line.
  always_comb begin : p_step
    cur_cnt   = cnt_q[line_q];
    kept_nxt  = (state_q == StPush) ? kept_q + CNT_W'(1) : kept_q;
    opt_nxt   = opt_k_q + CNT_W'(1);
    line_step = (state_q == StPush) ||
                ((state_q == StWait) && bus_io.res_valid && !bus_io.res_keep);
    eol       = (opt_nxt == cur_cnt);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_state_reg
    if (!rst_ni) begin
      state_q   <= StIdle;
      line_q    <= '0;
      kept_q    <= '0;
      opt_k_q   <= '0;
      changed_q <= 1'b0;
      hold_q    <= '0;
      cnt_q     <= '0;
      pass_q    <= '0;
      solved_q  <= 1'b0;
      stuck_q   <= 1'b0;
      contra_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      kept_q    <= kept_d;
      opt_k_q   <= opt_k_d;
      changed_q <= changed_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      solved_q  <= solved_d;
      stuck_q   <= stuck_d;
      contra_q  <= contra_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin : p_next
    state_d   = state_q;
    line_d    = line_q;
    kept_d    = kept_q;
    opt_k_d   = opt_k_q;
    changed_d = changed_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    solved_d  = solved_q;
    stuck_d   = stuck_q;
    contra_d  = contra_q;

    unique case (state_q)
      StIdle, StSolved, StStuck, StContra: begin
        // The count write lands in the same cycle; HDR reads it one cycle later.
        if (cnt_wr_en_i && (cnt_wr_idx_i < IDX_W'(NUM_SLOTS))) begin
          cnt_d[cnt_wr_idx_i] = cnt_wr_val_i;
        end
        if (start_i) begin
          solved_d  = 1'b0;
          stuck_d   = 1'b0;
          contra_d  = 1'b0;
          pass_d    = '0;
          changed_d = 1'b0;
          kept_d    = '0;
          line_d    = '0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (cur_cnt == '0) begin
          contra_d = 1'b1;
          state_d  = StContra;
        end else if (bus_io.sol_ready) begin
          kept_d  = '0;
          opt_k_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!bus_io.fifo_empty && bus_io.sol_ready) begin
          hold_d  = bus_io.fifo_dout;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus_io.res_valid) begin
          if (bus_io.res_keep) begin
            state_d = StPush;
          end else begin
            opt_k_d = opt_nxt;
            state_d = StIssue;
          end
        end
      end
      StPush: begin
        kept_d  = kept_nxt;
        opt_k_d = opt_nxt;
        state_d = StIssue;
      end
      StNext: begin
        if (!wrap) begin
          line_d  = next_line;
          state_d = StHdr;
        end else begin
          pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
          if (all_one) begin
            solved_d = 1'b1;
            state_d  = StSolved;
          end else if (!changed_q) begin
            stuck_d = 1'b1;
            state_d = StStuck;
          end else begin
            changed_d = 1'b0;
            line_d    = first_line;
            state_d   = StHdr;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Last option of the line: commit the surviving count.
    if (line_step && eol) begin
      cnt_d[line_q] = kept_nxt;
      if (kept_nxt != cur_cnt) changed_d = 1'b1;
      if (kept_nxt == '0) begin
        contra_d = 1'b1;
        state_d  = StContra;
      end else begin
        state_d = StNext;
      end
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin : p_out
    bus_io.sol_valid     = 1'b0;
    bus_io.sol_is_header = 1'b0;
    bus_io.sol_data      = '0;
    bus_io.fifo_rd       = 1'b0;
    bus_io.fifo_wr       = 1'b0;
    bus_io.fifo_din      = '0;
    unique case (state_q)
      StHdr: begin
        if (cur_cnt != '0) begin
          bus_io.sol_valid     = 1'b1;
          bus_io.sol_is_header = 1'b1;
          bus_io.sol_data      = OPT_W'(line_q);
        end
      end
      StIssue: begin
        bus_io.sol_valid = !bus_io.fifo_empty;
        bus_io.sol_data  = bus_io.fifo_dout;
        bus_io.fifo_rd   = !bus_io.fifo_empty && bus_io.sol_ready;
      end
      StPush: begin
        bus_io.fifo_wr  = 1'b1;
        bus_io.fifo_din = hold_q;
      end
      default: ;
    endcase
  end

  assign old_options_amnt_o = cnt_q;
  assign pass_cnt_o         = pass_q;
  assign busy_o             = (state_q == StHdr) || (state_q == StIssue) || (state_q == StWait) ||
                              (state_q == StPush) || (state_q == StNext);
  assign solved_o           = solved_q;
  assign stuck_o            = stuck_q;
  assign contradiction_o    = contra_q;

endmodule

// File: tb/tb_nonogram_line_scheduler.sv
// Scoreboard bench for nonogram_line_scheduler: a FIFO model and a scripted solver surround the
// DUT; expected solver words are queued per scenario and checked as the DUT hands them over.
module tb_nonogram_line_scheduler;
  import nonogram_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            start;
  logic [3:0]                      num_rows;
  logic [3:0]                      num_cols;
  logic                            cnt_wr_en;
  logic [IDX_W-1:0]                cnt_wr_idx;
  logic [CNT_W-1:0]                cnt_wr_val;
  logic [NUM_SLOTS-1:0][CNT_W-1:0] amnt;
  logic [7:0]                      pass_cnt;
  logic                            busy, solved, stuck, contra;

  always #5 clk = ~clk;

  nonogram_line_scheduler_if bus ();

  nonogram_line_scheduler dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .num_rows_i         (num_rows),
    .num_cols_i         (num_cols),
    .cnt_wr_en_i        (cnt_wr_en),
    .cnt_wr_idx_i       (cnt_wr_idx),
    .cnt_wr_val_i       (cnt_wr_val),
    .bus_io             (bus),
    .old_options_amnt_o (amnt),
    .pass_cnt_o         (pass_cnt),
    .busy_o             (busy),
    .solved_o           (solved),
    .stuck_o            (stuck),
    .contradiction_o    (contra)
  );

  typedef struct packed {
    logic             hdr;
    logic [OPT_W-1:0] data;
  } word_t;

  int               total = 0;
  int               bad = 0;
  word_t            exp_q[$];
  logic [OPT_W-1:0] fifo_q[$];
  int               fifo_n = 0;
  bit               force_empty = 1'b0;
  int               rd_count = 0;
  int               drop_mode = 0;
  int               cur_line = 0;
  int               ord = 0;
  int               pass_idx = -1;
  bit               hold_res = 1'b0;
  bit               pend = 1'b0;
  bit               pend_keep = 1'b0;

  assign bus.fifo_empty = force_empty || (fifo_n == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scripted verdicts: 1 = row0 drops ord 2 in pass 0 and ord 1 in pass 1; 2 = column 0 drops all.
  function automatic bit keep_fn(input int l, input int o, input int p);
    case (drop_mode)
      1: if (l == 0 && ((p == 0 && o == 2) || (p == 1 && o == 1))) return 1'b0;
      2: if (l == int'(MAX_SIZE)) return 1'b0;
      default: ;
    endcase
    return 1'b1;
  endfunction

  task automatic fifo_sync();
    fifo_n        = fifo_q.size();
    bus.fifo_dout = (fifo_n != 0) ? fifo_q[0] : '0;
  endtask

  // Monitor at negedge, FIFO/solver model update 1 time unit after posedge.
  initial begin
    forever begin
      logic             rd_ev, wr_ev;
      logic [OPT_W-1:0] wr_word;
      word_t            w;
      rd_ev = 1'b0;
      wr_ev = 1'b0;
      wr_word = '0;
      @(negedge clk);
      if (rst_n) begin
        rd_ev = bus.fifo_rd;
        wr_ev = bus.fifo_wr;
        wr_word = bus.fifo_din;
        if (bus.fifo_rd || bus.fifo_wr) check("rd_wr_exclusive", {31'b0, bus.fifo_rd & bus.fifo_wr}, 0);
        if (bus.sol_valid && !bus.sol_is_header && bus.fifo_empty)
          check("valid_on_empty", 1, 0);
        pend = 1'b0;
        if (bus.sol_valid && bus.sol_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", {15'b0, bus.sol_is_header, bus.sol_data}, 32'hFFFF_FFFF);
          end else begin
            w = exp_q.pop_front();
            check("word_is_header", {31'b0, bus.sol_is_header}, {31'b0, w.hdr});
            check("word_data", {16'b0, bus.sol_data}, {16'b0, w.data});
          end
          if (bus.sol_is_header) begin
            cur_line = int'(bus.sol_data);
            ord = 0;
            if (bus.sol_data == '0) pass_idx++;
          end else begin
            pend = !hold_res;
            pend_keep = keep_fn(cur_line, ord, pass_idx);
            ord++;
          end
        end
      end else begin
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (rd_ev && fifo_q.size() != 0) begin
          void'(fifo_q.pop_front());
          rd_count++;
        end
        if (wr_ev) fifo_q.push_back(wr_word);
        fifo_sync();
        bus.res_valid = pend;
        bus.res_keep  = pend_keep;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input int idx, input int val);
    cnt_wr_en  = 1'b1;
    cnt_wr_idx = IDX_W'(idx);
    cnt_wr_val = CNT_W'(val);
    tick();
    cnt_wr_en  = 1'b0;
  endtask

  // Last count load shares the cycle with start.
  task automatic start_with(input int idx, input int val);
    cnt_wr_en  = 1'b1;
    cnt_wr_idx = IDX_W'(idx);
    cnt_wr_val = CNT_W'(val);
    start      = 1'b1;
    tick();
    cnt_wr_en  = 1'b0;
    start      = 1'b0;
  endtask

  task automatic prep(input int mode, input int rows, input int cols);
    drop_mode = mode;
    pass_idx  = -1;
    ord       = 0;
    num_rows  = 4'(rows);
    num_cols  = 4'(cols);
  endtask

  task automatic exp_h(input int l);
    word_t w;
    w.hdr = 1'b1;
    w.data = OPT_W'(l);
    exp_q.push_back(w);
  endtask

  task automatic exp_o(input logic [OPT_W-1:0] d);
    word_t w;
    w.hdr = 1'b0;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("finish_in_budget", {31'b0, busy}, 0);
  endtask

  task automatic check_fifo(input logic [OPT_W-1:0] want[$]);
    check("fifo_len", fifo_q.size(), want.size());
    for (int i = 0; i < want.size() && i < fifo_q.size(); i++)
      check("fifo_word", {16'b0, fifo_q[i]}, {16'b0, want[i]});
  endtask

  task automatic check_flags(input bit s, input bit k, input bit c, input int p);
    check("busy", {31'b0, busy}, 0);
    check("solved", {31'b0, solved}, {31'b0, s});
    check("stuck", {31'b0, stuck}, {31'b0, k});
    check("contradiction", {31'b0, contra}, {31'b0, c});
    check("pass_cnt", {24'b0, pass_cnt}, p);
  endtask

  // 3x3 grid, one option per line, solver keeps everything.
  task automatic grid3_setup();
    logic [OPT_W-1:0] wq[$];
    prep(0, 3, 3);
    wq = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};
    fifo_q = wq;
    fifo_sync();
    load_cnt(0, 1); load_cnt(1, 1); load_cnt(2, 1);
    load_cnt(11, 1); load_cnt(12, 1);
    exp_h(0);  exp_o(16'h1000); exp_h(1);  exp_o(16'h1001); exp_h(2);  exp_o(16'h1002);
    exp_h(11); exp_o(16'h1003); exp_h(12); exp_o(16'h1004); exp_h(13); exp_o(16'h1005);
  endtask

  task automatic grid3_final();
    logic [OPT_W-1:0] wq[$];
    check("sb_drained", exp_q.size(), 0);
    check_flags(1'b1, 1'b0, 1'b0, 1);
    check("cnt_s0", {25'b0, amnt[0]}, 1);
    check("cnt_s13", {25'b0, amnt[13]}, 1);
    wq = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};
    check_fifo(wq);
  endtask

  initial begin
    logic [OPT_W-1:0] wq[$];
    int               rd0;
    int               n;
    rst_n = 1'b0;
    start = 1'b0;
    cnt_wr_en = 1'b0;
    cnt_wr_idx = '0;
    cnt_wr_val = '0;
    num_rows = 4'd1;
    num_cols = 4'd1;
    bus.sol_ready = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_keep = 1'b0;
    fifo_sync();
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_flags", {29'b0, solved, stuck, contra}, 0);
    check("rst_pass", {24'b0, pass_cnt}, 0);
    check("rst_counts", {31'b0, |amnt}, 0);
    check("rst_bus", {28'b0, bus.sol_valid, bus.sol_is_header, bus.fifo_rd, bus.fifo_wr}, 0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: straight solve, count load coinciding with start.
    grid3_setup();
    start_with(13, 1);
    wait_idle(500);
    grid3_final();

    // Scenario 2: row0 shrinks 3 -> 2 -> 1 over two passes.
    prep(1, 2, 2);
    wq = '{16'h2000, 16'h2001, 16'h2002, 16'h2010, 16'h2020, 16'h2030};
    fifo_q = wq;
    fifo_sync();
    load_cnt(0, 3); load_cnt(1, 1); load_cnt(11, 1);
    exp_h(0);  exp_o(16'h2000); exp_o(16'h2001); exp_o(16'h2002);
    exp_h(1);  exp_o(16'h2010); exp_h(11); exp_o(16'h2020); exp_h(12); exp_o(16'h2030);
    exp_h(0);  exp_o(16'h2000); exp_o(16'h2001);
`ifndef SKIP_SETTLED_EN
    exp_h(1);  exp_o(16'h2010); exp_h(11); exp_o(16'h2020); exp_h(12); exp_o(16'h2030);
`endif
    start_with(12, 1);
    wait_idle(500);
    check("sb_drained", exp_q.size(), 0);
    check_flags(1'b1, 1'b0, 1'b0, 2);
    check("cnt_row0", {25'b0, amnt[0]}, 1);
`ifdef SKIP_SETTLED_EN
    wq = '{16'h2010, 16'h2020, 16'h2030, 16'h2000};
`else
    wq = '{16'h2000, 16'h2010, 16'h2020, 16'h2030};
`endif
    check_fifo(wq);

    // Scenario 3: row1 keeps both options, nothing changes -> stuck after one pass.
    prep(0, 2, 2);
    wq = '{16'h3000, 16'h3010, 16'h3011, 16'h3020, 16'h3030};
    fifo_q = wq;
    fifo_sync();
    load_cnt(0, 1); load_cnt(1, 2); load_cnt(11, 1);
    exp_h(0);  exp_o(16'h3000); exp_h(1);  exp_o(16'h3010); exp_o(16'h3011);
    exp_h(11); exp_o(16'h3020); exp_h(12); exp_o(16'h3030);
    start_with(12, 1);
    wait_idle(500);
    check("sb_drained", exp_q.size(), 0);
    check_flags(1'b0, 1'b1, 1'b0, 1);
    check("cnt_row1", {25'b0, amnt[1]}, 2);
    check_fifo(wq);

    // Scenario 4: column 0 loses all three options -> contradiction.
    prep(2, 1, 1);
    wq = '{16'h4000, 16'h4010, 16'h4011, 16'h4012};
    fifo_q = wq;
    fifo_sync();
    load_cnt(0, 1);
    exp_h(0); exp_o(16'h4000);
    exp_h(11); exp_o(16'h4010); exp_o(16'h4011); exp_o(16'h4012);
    start_with(11, 3);
    wait_idle(500);
    check("sb_drained", exp_q.size(), 0);
    check_flags(1'b0, 1'b0, 1'b1, 0);
    check("cnt_col0", {25'b0, amnt[11]}, 0);
    wq = '{16'h4000};
    check_fifo(wq);

    // Scenario 5: solver stalls the header, then the FIFO runs dry for four cycles.
    grid3_setup();
    bus.sol_ready = 1'b0;
    force_empty = 1'b1;
    start_with(13, 1);
    repeat (5) tick();
    check("stall_hdr_valid", {30'b0, bus.sol_valid, bus.sol_is_header}, 3);
    check("stall_hdr_data", {16'b0, bus.sol_data}, 0);
    rd0 = rd_count;
    bus.sol_ready = 1'b1;
    tick();
    repeat (4) tick();
    check("empty_no_valid", {31'b0, bus.sol_valid}, 0);
    check("empty_no_pop", rd_count, rd0);
    check("empty_busy", {31'b0, busy}, 1);
    force_empty = 1'b0;
    wait_idle(500);
    grid3_final();

    // Scenario 6: reset while waiting on a verdict, then a clean rerun.
    grid3_setup();
    hold_res = 1'b1;
    rd0 = rd_count;
    start_with(13, 1);
    n = 0;
    while (rd_count == rd0 && n < 50) begin
      tick();
      n++;
    end
    check("pop_before_reset", {31'b0, rd_count != rd0}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", {31'b0, busy}, 0);
    check("async_bus", {30'b0, bus.sol_valid, bus.fifo_wr}, 0);
    check("async_counts", {31'b0, |amnt}, 0);
    fifo_q.delete();
    fifo_sync();
    exp_q.delete();
    hold_res = 1'b0;
    pend = 1'b0;
    bus.res_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    grid3_setup();
    start_with(13, 1);
    wait_idle(500);
    grid3_final();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
